// File: rtl/swipt_pkg.sv
// Shared SWIPT transmitter constants and types, used by duty adjust and the PWM stage.
package swipt_pkg;

  localparam logic [11:0] SWIPT_PERIOD    = 12'h1F4;
  localparam int unsigned SWIPT_DUTY_W    = 12;
  localparam int unsigned SWIPT_DEAD_TIME = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StDeadLh,
    StHigh,
    StDeadHl
  } pwm_state_t;

endpackage

// File: rtl/swipt_deadtime_gen.sv
// Raw PWM to complementary half-bridge gate drives, with a fixed dead window on every
// gate transition. Gate outputs are registered alongside the state.
module swipt_deadtime_gen
  import swipt_pkg::*;
#(
  parameter int unsigned W         = SWIPT_DUTY_W,
  parameter int unsigned DEAD_TIME = SWIPT_DEAD_TIME
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic raw,
  output logic gateHigh,
  output logic gateLow
);

  localparam logic [W-1:0] DeadLoad = W'(DEAD_TIME - 1);

  pwm_state_t   state_q;
  logic [W-1:0] dead_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      dead_cnt_q <= '0;
      gateHigh   <= 1'b0;
      gateLow    <= 1'b0;
    end else if (!en) begin
      state_q    <= StIdle;
      dead_cnt_q <= '0;
      gateHigh   <= 1'b0;
      gateLow    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StDeadHl;
          dead_cnt_q <= DeadLoad;
        end
        StLow: begin
          if (raw) begin
            state_q    <= StDeadLh;
            dead_cnt_q <= DeadLoad;
            gateLow    <= 1'b0;
          end
        end
        StHigh: begin
          if (!raw) begin
            state_q    <= StDeadHl;
            dead_cnt_q <= DeadLoad;
            gateHigh   <= 1'b0;
          end
        end
        StDeadLh, StDeadHl: begin
          // The window runs to completion; raw is only consulted when it expires.
          if (dead_cnt_q == '0) begin
            if (raw) begin
              state_q  <= StHigh;
              gateHigh <= 1'b1;
            end else begin
              state_q  <= StLow;
              gateLow  <= 1'b1;
            end
          end else begin
            dead_cnt_q <= dead_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          dead_cnt_q <= '0;
          gateHigh   <= 1'b0;
          gateLow    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/swipt_pwm_driver.sv
// SWIPT PWM stage: period counter, boundary-loaded shadow duty with clamp, and the
// dead-time gate generator.
module swipt_pwm_driver
  import swipt_pkg::*;
#(
  parameter int unsigned PERIOD    = 500,
  parameter int unsigned DEAD_TIME = SWIPT_DEAD_TIME,
  parameter int unsigned W         = SWIPT_DUTY_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         swiptAlive,
  input  logic [W-1:0] dutyCycle,
  output logic         gateHigh,
  output logic         gateLow,
  output logic         periodStart,
  output logic [W-1:0] dutyApplied
);

  localparam logic [W-1:0] PeriodW = W'(PERIOD);
  localparam logic [W-1:0] LastCnt = W'(PERIOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] duty_clamped;
  logic         run_q;
  logic         raw;

  assign duty_clamped = (dutyCycle > PeriodW) ? PeriodW : dutyCycle;

  // run_q holds cnt at 0 for the first cycle after enable so that cycle is a period start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= '0;
      run_q       <= 1'b0;
      dutyApplied <= '0;
    end else if (!swiptAlive) begin
      cnt_q       <= '0;
      run_q       <= 1'b0;
      dutyApplied <= duty_clamped;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
      end
      if (cnt_q == LastCnt) begin
        dutyApplied <= duty_clamped;
      end
    end
  end

  assign raw         = (cnt_q < dutyApplied);
  assign periodStart = run_q && (cnt_q == '0);

  swipt_deadtime_gen #(
    .W         (W),
    .DEAD_TIME (DEAD_TIME)
  ) u_deadtime_gen (
    .clk      (clk),
    .nrst     (nrst),
    .en       (swiptAlive),
    .raw      (raw),
    .gateHigh (gateHigh),
    .gateLow  (gateLow)
  );

endmodule

// File: tb/tb_swipt_pwm_driver.sv
// Bench for swipt_pwm_driver: cycle-level behavioural model compared every cycle, plus
// directed literal checks of duty cycles, latencies, disable and reset behaviour.
module tb_swipt_pwm_driver;

  localparam int Per = 500;
  localparam int Dt  = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        swiptAlive;
  logic [11:0] dutyCycle;
  logic        gateHigh, gateLow, periodStart;
  logic [11:0] dutyApplied;

  int  n_pass = 0;
  int  n_total = 0;
  bit  cmp_en = 0;

  swipt_pwm_driver dut (
    .clk         (clk),
    .nrst        (nrst),
    .swiptAlive  (swiptAlive),
    .dutyCycle   (dutyCycle),
    .gateHigh    (gateHigh),
    .gateLow     (gateLow),
    .periodStart (periodStart),
    .dutyApplied (dutyApplied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: position in period, shadow duty, gate side (0 off, 1 high, 2 low)
  // and remaining dead cycles.
  int m_cnt, m_duty, m_out, m_hold;
  bit m_run, m_idle;

  function automatic int clampd(input int d);
    return (d > Per) ? Per : d;
  endfunction

  always @(posedge clk or negedge nrst) begin
    bit raw;
    if (!nrst) begin
      m_run = 0; m_cnt = 0; m_duty = 0; m_out = 0; m_hold = 0; m_idle = 1;
    end else if (!swiptAlive) begin
      m_run = 0; m_cnt = 0; m_out = 0; m_hold = 0; m_idle = 1;
      m_duty = clampd(int'(dutyCycle));
    end else begin
      raw = (m_cnt < m_duty);
      if (m_idle) begin
        m_idle = 0; m_out = 0; m_hold = Dt;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_out = raw ? 1 : 2;
      end else if ((m_out == 1) != raw) begin
        m_out = 0; m_hold = Dt;
      end
      if (m_cnt == Per - 1) m_duty = clampd(int'(dutyCycle));
      m_cnt = m_run ? (m_cnt + 1) % Per : 0;
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gateHigh", 32'(gateHigh), 32'(m_out == 1));
      chk("gateLow", 32'(gateLow), 32'(m_out == 2));
      chk("periodStart", 32'(periodStart), 32'(m_run && m_cnt == 0));
      chk("dutyApplied", 32'(dutyApplied), 32'(m_duty));
      chk("no_overlap", 32'(gateHigh && gateLow), 32'd0);
      assert (!(gateHigh && gateLow)) else $error("gates overlap");
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ps();
    for (int i = 0; i < Per + 100; i++) begin
      step(1);
      if (periodStart) return;
    end
    chk("periodStart_timeout", 32'd0, 32'd1);
  endtask

  // Counts gate activity over one full period starting at the current cycle.
  task automatic count_period(output int h, output int l, output int z, output int ps);
    h = 0; l = 0; z = 0; ps = 0;
    for (int i = 0; i < Per; i++) begin
      if (gateHigh) h++;
      if (gateLow) l++;
      if (!gateHigh && !gateLow) z++;
      if (periodStart) ps++;
      step(1);
    end
  endtask

  int h, l, z, ps, k;

  initial begin
    nrst = 1'b0;
    swiptAlive = 1'b0;
    dutyCycle = 12'd250;
    step(3);
    chk("rst_gateHigh", 32'(gateHigh), 32'd0);
    chk("rst_gateLow", 32'(gateLow), 32'd0);
    chk("rst_periodStart", 32'(periodStart), 32'd0);
    chk("rst_dutyApplied", 32'(dutyApplied), 32'd0);
    nrst = 1'b1;
    cmp_en = 1;
    step(2);
    chk("idle_load_duty", 32'(dutyApplied), 32'd250);

    swiptAlive = 1'b1;
    step(1);
    chk("first_periodStart", 32'(periodStart), 32'd1);
    chk("first_dead_gates", 32'(gateHigh || gateLow), 32'd0);
    wait_ps();
    count_period(h, l, z, ps);
    chk("d250_high", 32'(h), 32'd242);
    chk("d250_low", 32'(l), 32'd242);
    chk("d250_dead", 32'(z), 32'(2 * Dt));
    chk("d250_ps_count", 32'(ps), 32'd1);
    chk("d250_ps_next", 32'(periodStart), 32'd1);

    step(300);
    dutyCycle = 12'd100;
    step(199);
    chk("duty_hold_at_499", 32'(dutyApplied), 32'd250);
    step(1);
    chk("duty_applied_after_499", 32'(dutyApplied), 32'd100);
    count_period(h, l, z, ps);
    chk("d100_high", 32'(h), 32'd92);
    chk("d100_low", 32'(l), 32'd392);

    dutyCycle = 12'd0;
    wait_ps();
    count_period(h, l, z, ps);
    chk("d0_high", 32'(h), 32'd0);
    chk("d0_low", 32'(l), 32'd500);

    dutyCycle = 12'd600;
    wait_ps();
    chk("d600_clamped", 32'(dutyApplied), 32'd500);
    wait_ps();
    count_period(h, l, z, ps);
    chk("d600_high", 32'(h), 32'd500);

    dutyCycle = 12'd5;
    wait_ps();
    wait_ps();
    count_period(h, l, z, ps);
    chk("d5_high", 32'(h), 32'd0);
    chk("d5_low", 32'(l), 32'd492);
    chk("d5_dead", 32'(z), 32'(Dt));

    dutyCycle = 12'd250;
    wait_ps();
    wait_ps();
    step(120);
    chk("mid_high_before_drop", 32'(gateHigh), 32'd1);
    swiptAlive = 1'b0;
    step(1);
    chk("drop_gateHigh", 32'(gateHigh), 32'd0);
    chk("drop_gateLow", 32'(gateLow), 32'd0);
    chk("drop_periodStart", 32'(periodStart), 32'd0);
    step(2);
    swiptAlive = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (gateHigh || gateLow) break;
      k++;
    end
    chk("reenable_dead_cycles", 32'(k), 32'(Dt));

    step(37);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_gateHigh", 32'(gateHigh), 32'd0);
    chk("async_rst_gateLow", 32'(gateLow), 32'd0);
    chk("async_rst_duty", 32'(dutyApplied), 32'd0);
    chk("async_rst_ps", 32'(periodStart), 32'd0);
    step(2);
    nrst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      step($urandom_range(1, 800));
      if ($urandom_range(0, 5) == 0) begin
        swiptAlive = 1'b0;
        step($urandom_range(1, 4));
        swiptAlive = 1'b1;
      end
      case ($urandom_range(0, 4))
        0: dutyCycle = 12'($urandom_range(0, Dt));
        1: dutyCycle = 12'($urandom_range(Per - Dt, 4095));
        default: dutyCycle = 12'($urandom_range(0, 700));
      endcase
    end
    step(600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/swipt_pwm_driver.md
# swipt_pwm_driver

Downstream PWM stage for the SWIPT transmitter: consumes the 12-bit `dutyCycle` word produced by the duty-adjust stage and turns it into complementary half-bridge gate drives with dead-time. The 500-count carrier is fixed. Duty updates are shadow-loaded at period boundaries so a mid-period change never produces a runt pulse. The block sits between duty adjust and the gate-driver pins.

## Interface
- `PERIOD`, 500: counts per carrier period; duty full-scale (0x1F4).
- `DEAD_TIME`, 8: cycles with both gates off at every gate transition (≥1).
- `W`, 12: duty word width.

- `clk` input 1: system clock, shared with the duty-adjust stage.
- `nrst` input 1: reset, asynchronous, active-low.
- `swiptAlive` input 1: link enable. Low forces the safe state.
- `dutyCycle` input W: requested high-side on-count per period, from duty adjust.
- `gateHigh` output 1: high-side gate drive, registered.
- `gateLow` output 1: low-side gate drive, registered.
- `periodStart` output 1: one-cycle pulse on the cycle where the period counter is 0.
- `dutyApplied` output W: shadow duty currently in force. It is clamped.

## Operation
- Period counter `cnt` runs 0..PERIOD-1 and wraps to 0.
- Shadow duty `dutyApplied` loads `min(dutyCycle, PERIOD)` on the clock edge where `cnt == PERIOD-1`. It takes effect from the next `cnt == 0`.
- Raw PWM is combinational from registers: `raw = (cnt < dutyApplied)`.
  - Duty 0 gives raw constantly 0.
  - Duty ≥ PERIOD gives raw constantly 1.
- Dead-time FSM states: IDLE, LOW, DEAD_LH, HIGH, DEAD_HL. The dead counter is W bits and loads DEAD_TIME-1 on entry to a DEAD state.
  - IDLE: both gates off. When `swiptAlive` is 1, go to DEAD_HL.
  - LOW: `gateLow` = 1. If raw = 1, go to DEAD_LH.
  - HIGH: `gateHigh` = 1. If raw = 0, go to DEAD_HL.
  - DEAD_LH and DEAD_HL: both gates off. Stay DEAD_TIME cycles, then go to HIGH if raw = 1, else LOW. A raw change during the dead window does not restart the timer. Pulses shorter than DEAD_TIME are swallowed; the gates never overlap.
- Gate outputs are decoded registered from the state: `gateHigh` = (state == HIGH), `gateLow` = (state == LOW).
- `gateHigh && gateLow` must never be 1. This is an invariant and has an assertion in the bench.
- `swiptAlive` low (sampled synchronously) forces all of the following on the next edge:
  - state IDLE, `cnt` = 0, dead counter = 0;
  - `dutyApplied` = `min(dutyCycle, PERIOD)`.
  This gives a clean restart at 0 with the current request. `swiptAlive` low overrides every other event in that cycle.

## Timing
- Reset values: `gateHigh` 0, `gateLow` 0, `periodStart` 0, `dutyApplied` 0, `cnt` 0, state IDLE.
- Reset is asynchronous on assertion. Deassertion is assumed synchronized upstream.
- `periodStart` is high in the cycle where `cnt == 0`, including the first cycle after leaving IDLE.
- Duty latency: a `dutyCycle` change sampled at `cnt == PERIOD-1` is visible on `dutyApplied` one cycle later. A change at any other `cnt` is ignored until the next boundary.
- Gate latency: a raw rising edge at cycle t gives `gateLow` low at t+1 and `gateHigh` high at t+1+DEAD_TIME.
- Steady state with DEAD_TIME < d < PERIOD-DEAD_TIME:
  - `gateHigh` is high d−DEAD_TIME cycles per period.
  - `gateLow` is high PERIOD−d−DEAD_TIME cycles per period.
  - Both gates are low 2·DEAD_TIME cycles per period.

## Structure
- Shared package `swipt_pkg`, also used by duty adjust:
  - `SWIPT_PERIOD` = 12'h1F4;
  - `SWIPT_DUTY_W` = 12;
  - `SWIPT_DEAD_TIME`;
  - FSM state enum `pwm_state_t`.
- One sub-module, `swipt_deadtime_gen`: the raw-to-complementary FSM plus dead counter. Its inputs are `clk`, `nrst`, `en`, `raw`. Its outputs are `gateHigh` and `gateLow`.
- The top module holds the period counter, the shadow register and the clamp.

## Test plan
- Reset with `dutyCycle` = 250, then `swiptAlive` = 1: `gateHigh` high 242 cycles and `gateLow` high 242 cycles per 500. Both low for 8 cycles twice per period. `periodStart` every 500 cycles.
- `dutyCycle` 250→100 at `cnt` = 300: the current period keeps 250. The next period gives `gateHigh` 92 cycles and `gateLow` 392 cycles. `dutyApplied` changes exactly one cycle after `cnt` = 499.
- `dutyCycle` = 0 and `dutyCycle` = 600: for 0, `gateHigh` is never 1 and `gateLow` stays 1 after the initial dead window. For 600, `dutyApplied` = 500 and `gateHigh` stays 1.
- `dutyCycle` = 5 (< DEAD_TIME): `gateHigh` is never asserted. `gateLow` drops for 8 cycles each period, with no overlap.
- `swiptAlive` dropped mid-HIGH at `cnt` = 120: both gates are 0 on the next edge and `cnt` is 0. On re-enable, 8 dead cycles pass before the first gate asserts. `nrst` pulsed mid-period clears all outputs immediately, without waiting for a clock edge.
